// File: rtl/irrigation_cycle_ctrl_if.sv
// Purpose: bundles the panel/sensor inputs and the valve/display outputs of
//          the irrigation cycle controller into one port.
// Ports:   start/mode/us/alin/abort (panel/sensors -> controller),
//          valve_sprk/valve_drip/run/sec_tens/sec_ones/sec_tick/done/fault
//          (controller -> valve drivers and seconds display).
// Modports: master = panel/sensor side, slave = controller side.
interface irrigation_cycle_ctrl_if;
  logic       start;
  logic       mode;
  logic       us;
  logic       alin;
  logic       abort;
  logic       valve_sprk;
  logic       valve_drip;
  logic       run;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_tick;
  logic       done;
  logic       fault;

  modport master (
    output start, mode, us, alin, abort,
    input  valve_sprk, valve_drip, run, sec_tens, sec_ones, sec_tick, done, fault
  );

  modport slave (
    input  start, mode, us, alin, abort,
    output valve_sprk, valve_drip, run, sec_tens, sec_ones, sec_tick, done, fault
  );
endinterface

// File: rtl/irrigation_cycle_ctrl.sv
// Purpose: sequences one irrigation cycle -- start request, mode-dependent
//          BCD seconds countdown with the matching valve open, pause on low
//          water supply (alin), early end on wet soil (us), abort to idle.
// Latency: all outputs registered; first sec_tick TICK_DIV cycles after RUN entry.
// Backpressure: none; inputs are levels sampled each clock, start is only
//          honoured in IDLE.
// Ports:   clk, rst_n (async active-low); io (slave modport): start, mode, us,
//          alin, abort in; valve_sprk, valve_drip, run, sec_tens, sec_ones,
//          sec_tick, done, fault out.
// Build option: define LOW_WATER_TIMEOUT_EN to bound the time spent in HOLD;
//          after HOLD_LIMIT_SEC full seconds the controller parks in FAULT.
module irrigation_cycle_ctrl #(
  parameter int TICK_DIV       = 50000000,
  parameter int SPRINKLER_SEC  = 45,
  parameter int DRIP_SEC       = 90,
  parameter int HOLD_LIMIT_SEC = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  irrigation_cycle_ctrl_if.slave  io
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Load values are split into BCD digits at elaboration time.
  localparam logic [3:0] SPRK_TENS = 4'(SPRINKLER_SEC / 10);
  localparam logic [3:0] SPRK_ONES = 4'(SPRINKLER_SEC % 10);
  localparam logic [3:0] DRIP_TENS = 4'(DRIP_SEC / 10);
  localparam logic [3:0] DRIP_ONES = 4'(DRIP_SEC % 10);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef LOW_WATER_TIMEOUT_EN
  localparam logic [2:0] S_FAULT = 3'd5;
  localparam int HSW = $clog2(HOLD_LIMIT_SEC + 1);
  localparam logic [HSW-1:0] HSEC_LAST = HSW'(HOLD_LIMIT_SEC - 1);
`endif

  logic [2:0]    state_q,      state_d;
  logic          mode_q,       mode_d;
  logic [3:0]    tens_q,       tens_d;
  logic [3:0]    ones_q,       ones_d;
  logic [PW-1:0] presc_q,      presc_d;
  logic          sec_tick_q,   sec_tick_d;
  logic          done_q,       done_d;
  logic          run_q,        run_d;
  logic          valve_sprk_q, valve_sprk_d;
  logic          valve_drip_q, valve_drip_d;
`ifdef LOW_WATER_TIMEOUT_EN
  logic          fault_q,      fault_d;
  logic [PW-1:0] hpresc_q,     hpresc_d;
  logic [HSW-1:0] hsec_q,      hsec_d;
  logic          hold_expired;
`endif

  logic tick;
  assign tick = (presc_q == PRESC_MAX);

`ifdef LOW_WATER_TIMEOUT_EN
  // The hold timer is held at zero outside HOLD, so it starts fresh on every entry.
  always_comb begin
    hpresc_d = '0;
    hsec_d   = '0;
    if (state_q == S_HOLD) begin
      if (hpresc_q == PRESC_MAX) begin
        hpresc_d = '0;
        hsec_d   = hsec_q + 1'b1;
      end else begin
        hpresc_d = hpresc_q + 1'b1;
        hsec_d   = hsec_q;
      end
    end
  end

  assign hold_expired = (state_q == S_HOLD) && (hpresc_q == PRESC_MAX) &&
                        (hsec_q == HSEC_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    presc_d    = presc_q;
    sec_tick_d = 1'b0;

    if (state_q != S_IDLE && io.abort) begin
      state_d = S_IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Starting onto already-wet soil would end immediately; ignore it.
          if (io.start && !io.us) state_d = S_LOAD;
        end
        S_LOAD: begin
          mode_d  = io.mode;
          tens_d  = io.mode ? DRIP_TENS : SPRK_TENS;
          ones_d  = io.mode ? DRIP_ONES : SPRK_ONES;
          presc_d = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (io.us) begin
            state_d = S_DONE;
          end else if (io.alin) begin
            // Prescaler keeps its phase so the interrupted second resumes.
            state_d = S_HOLD;
          end else if (tick) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (tens_q == 4'd0 && ones_q == 4'd1) state_d = S_DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (io.us) begin
            state_d = S_DONE;
          end else if (!io.alin) begin
            state_d = S_RUN;
          end
`ifdef LOW_WATER_TIMEOUT_EN
          else if (hold_expired) begin
            state_d = S_FAULT;
          end
`endif
        end
        S_DONE: state_d = S_IDLE;
`ifdef LOW_WATER_TIMEOUT_EN
        S_FAULT: state_d = S_FAULT;
`endif
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered versions of the next-state decode.
    run_d        = (state_d == S_RUN);
    valve_sprk_d = run_d & ~mode_d;
    valve_drip_d = run_d &  mode_d;
    done_d       = (state_d == S_DONE);
`ifdef LOW_WATER_TIMEOUT_EN
    fault_d      = (state_d == S_FAULT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      presc_q      <= '0;
      sec_tick_q   <= 1'b0;
      done_q       <= 1'b0;
      run_q        <= 1'b0;
      valve_sprk_q <= 1'b0;
      valve_drip_q <= 1'b0;
`ifdef LOW_WATER_TIMEOUT_EN
      fault_q      <= 1'b0;
      hpresc_q     <= '0;
      hsec_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      presc_q      <= presc_d;
      sec_tick_q   <= sec_tick_d;
      done_q       <= done_d;
      run_q        <= run_d;
      valve_sprk_q <= valve_sprk_d;
      valve_drip_q <= valve_drip_d;
`ifdef LOW_WATER_TIMEOUT_EN
      fault_q      <= fault_d;
      hpresc_q     <= hpresc_d;
      hsec_q       <= hsec_d;
`endif
    end
  end

  assign io.valve_sprk = valve_sprk_q;
  assign io.valve_drip = valve_drip_q;
  assign io.run        = run_q;
  assign io.sec_tens   = tens_q;
  assign io.sec_ones   = ones_q;
  assign io.sec_tick   = sec_tick_q;
  assign io.done       = done_q;
`ifdef LOW_WATER_TIMEOUT_EN
  assign io.fault      = fault_q;
`else
  assign io.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_irrigation_cycle_ctrl.sv
// Bench for irrigation_cycle_ctrl with TICK_DIV=4, SPRINKLER_SEC=3,
// DRIP_SEC=12, HOLD_LIMIT_SEC=2. The stimulus script walks cycle by cycle and
// queues the expected output snapshot for every cycle it wants inspected; the
// monitor pops one entry for every probed cycle or DUT tick/done pulse.
`timescale 1ns/1ps
module tb_irrigation_cycle_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SPRK     = 3;
  localparam int DRIP     = 12;
  localparam int HOLD_LIM = 2;
`ifdef LOW_WATER_TIMEOUT_EN
  localparam int HOLD_CYC = 5;
`else
  localparam int HOLD_CYC = 10;
`endif

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick;
    logic       done;
    logic       sprk;
    logic       drip;
    logic       run;
    logic       fault;
  } snap_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  logic  probe = 1'b0;
  int    tests = 0;
  int    fails = 0;
  snap_t exp_q[$];
  string name_q[$];

  irrigation_cycle_ctrl_if bus();

  irrigation_cycle_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .SPRINKLER_SEC (SPRK),
    .DRIP_SEC      (DRIP),
    .HOLD_LIMIT_SEC(HOLD_LIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [3:0] t, input logic [3:0] o,
                               input logic tk, input logic dn, input logic sp,
                               input logic dr, input logic rn, input logic ft);
    snap_t s;
    s.tens = t; s.ones = o; s.tick = tk; s.done = dn;
    s.sprk = sp; s.drip = dr; s.run = rn; s.fault = ft;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("digits=%0d%0d tick=%b done=%b sprk=%b drip=%b run=%b fault=%b",
                     s.tens, s.ones, s.tick, s.done, s.sprk, s.drip, s.run, s.fault);
  endfunction

  // Monitor: one comparison per probed cycle or per DUT event pulse.
  always @(negedge clk) begin : monitor
    snap_t act;
    snap_t e;
    string n;
    if (probe || bus.sec_tick || bus.done) begin
      act = mk(bus.sec_tens, bus.sec_ones, bus.sec_tick, bus.done,
               bus.valve_sprk, bus.valve_drip, bus.run, bus.fault);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got {%s} required no event", fmt(act));
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL %s got {%s} required {%s}", n, fmt(act), fmt(e));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      probe = 1'b0;
    end
  endtask

  task automatic chk(input string n, input snap_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
    probe = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.us = 1'b0;
    bus.alin  = 1'b0; bus.abort = 1'b0;

    step(2);
    chk("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(1);
    rst_n = 1'b1;
    step(1);

    // 1: sprinkler cycle 03 -> 02 -> 01 -> 00 + done
    bus.start = 1'b1; bus.mode = 1'b0; step(1);
    bus.start = 1'b0; step(1);
    chk("t1_run_entry", mk(0, 3, 0, 0, 1, 0, 1, 0)); step(4);
    chk("t1_tick02",    mk(0, 2, 1, 0, 1, 0, 1, 0)); step(4);
    chk("t1_tick01",    mk(0, 1, 1, 0, 1, 0, 1, 0)); step(4);
    chk("t1_tick00",    mk(0, 0, 1, 1, 0, 0, 0, 0)); step(1);
    chk("t1_idle",      mk(0, 0, 0, 0, 0, 0, 0, 0)); step(2);

    // 2: drip cycle 12 -> 11 -> 10 -> 09
    bus.start = 1'b1; bus.mode = 1'b1; step(1);
    bus.start = 1'b0; step(1);
    chk("t2_run_entry", mk(1, 2, 0, 0, 0, 1, 1, 0)); step(4);
    chk("t2_tick11",    mk(1, 1, 1, 0, 0, 1, 1, 0)); step(4);
    chk("t2_tick10",    mk(1, 0, 1, 0, 0, 1, 1, 0)); step(4);
    chk("t2_tick09",    mk(0, 9, 1, 0, 0, 1, 1, 0)); step(2);

    // 3: low water with prescaler phase 2; resume ticks after 2 cycles
    bus.alin = 1'b1; step(1);
    chk("t3_hold",        mk(0, 9, 0, 0, 0, 0, 0, 0)); step(3);
    chk("t3_hold_frozen", mk(0, 9, 0, 0, 0, 0, 0, 0)); step(HOLD_CYC - 4);
    bus.alin = 1'b0; step(1);
    chk("t3_resume",      mk(0, 9, 0, 0, 0, 1, 1, 0)); step(2);
    chk("t3_tick08",      mk(0, 8, 1, 0, 0, 1, 1, 0)); step(1);

    // 4: wet soil ends the cycle; start with wet soil is ignored
    bus.us = 1'b1; step(1);
    chk("t4_wet_done", mk(0, 8, 0, 1, 0, 0, 0, 0)); step(1);
    bus.start = 1'b1; step(3);
    chk("t4_no_load",  mk(0, 8, 0, 0, 0, 0, 0, 0));
    bus.start = 1'b0; bus.us = 1'b0; step(1);

    // 5: asynchronous reset mid-RUN, then abort from HOLD
    bus.mode = 1'b0; bus.start = 1'b1; step(1);
    bus.start = 1'b0; step(2);
    rst_n = 1'b0; #1;
    chk("t5_async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0)); step(1);
    rst_n = 1'b1; step(1);
    bus.start = 1'b1; step(1);
    bus.start = 1'b0; step(1);
    bus.alin = 1'b1; step(1);
    chk("t5_hold",       mk(0, 3, 0, 0, 0, 0, 0, 0));
    bus.abort = 1'b1; step(1);
    chk("t5_abort_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
    bus.abort = 1'b0; bus.alin = 1'b0; step(3);

    // 6: long low-water hold
    bus.start = 1'b1; step(1);
    bus.start = 1'b0; step(1);
    bus.alin = 1'b1; step(8);
    chk("t6_hold_pre_limit", mk(0, 3, 0, 0, 0, 0, 0, 0)); step(1);
`ifdef LOW_WATER_TIMEOUT_EN
    chk("t6_fault", mk(0, 3, 0, 0, 0, 0, 0, 1));
    bus.alin = 1'b0; bus.us = 1'b1; step(1);
    bus.us = 1'b0; step(1);
    bus.us = 1'b1; step(1);
    chk("t6_fault_sticky", mk(0, 3, 0, 0, 0, 0, 0, 1));
    bus.us = 1'b0; bus.abort = 1'b1; step(1);
    chk("t6_abort_clears", mk(0, 0, 0, 0, 0, 0, 0, 0));
`else
    chk("t6_no_fault", mk(0, 3, 0, 0, 0, 0, 0, 0));
    bus.abort = 1'b1; step(1);
    chk("t6_abort_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
`endif
    bus.abort = 1'b0; bus.alin = 1'b0;
    step(3);

    while (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s got no sample required {%s}", name_q.pop_front(),
               fmt(exp_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
